// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 5x5 Gabor window sequencer.
package conv_seq_pkg;
  localparam int KSIZE     = 5;
  localparam int DIM_W_MAX = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [DIM_W_MAX-1:0] row;
    logic [DIM_W_MAX-1:0] col;
  } win_coord_t;

  // Five signed group products need three guard bits to sum without overflow.
  function automatic int sum_w(input int res_w);
    return res_w + 3;
  endfunction
endpackage

// File: rtl/conv_window_sequencer_if.sv
// Window-issue, datapath-product and result-stream signals of the sequencer.
interface conv_window_sequencer_if import conv_seq_pkg::*; #(
  parameter int DIM_W = 10,
  parameter int RES_W = 29
);
  logic                          win_valid, win_ready;
  logic [DIM_W-1:0]              win_row, win_col;
  logic signed [RES_W-1:0]       res1, res2, res3, res4, res5;
  logic                          out_valid, out_ready, out_last;
  logic signed [sum_w(RES_W)-1:0] out_data;

  modport master (
    output win_valid, win_row, win_col, out_valid, out_data, out_last,
    input  win_ready, res1, res2, res3, res4, res5, out_ready
  );
  modport slave (
    input  win_valid, win_row, win_col, out_valid, out_data, out_last,
    output win_ready, res1, res2, res3, res4, res5, out_ready
  );
endinterface

// File: rtl/conv_seq_fifo.sv
// First-word-fall-through synchronous FIFO; head is read straight from the storage registers.
module conv_seq_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  // Issue credits make this unreachable; firing means the credit loop is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/conv_window_sequencer.sv
// Raster-order 5x5 window issuer with in-flight tracking, product summation and credited output FIFO.
// Optional stall/backpressure counters under CONV_SEQ_STALL_CNT_EN.
module conv_window_sequencer import conv_seq_pkg::*; #(
  parameter int DIM_W     = 10,
  parameter int RES_W     = 29,
  parameter int PIPE_LAT  = 3,
  parameter int OUT_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  output logic             busy,
  output logic             done,
`ifdef CONV_SEQ_STALL_CNT_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      bp_cycles,
`endif
  conv_window_sequencer_if.master bus
);
  localparam int SUM_W = sum_w(RES_W);
  localparam int CW    = $clog2(OUT_DEPTH) + 1;
  localparam logic [DIM_W-1:0] K = DIM_W'(KSIZE);

  state_e                state_q;
  logic                  busy_q, done_q;
  logic [DIM_W-1:0]      w_q, h_q;
  win_coord_t            coord_q;
  logic [CW-1:0]         credit_q;
  logic [PIPE_LAT-1:0]   vld_pipe_q, last_pipe_q;
  logic                  win_valid, accept, pop, start_ok;
  logic                  col_end, row_end, win_last;
  logic signed [SUM_W-1:0] sum;
  logic [SUM_W:0]        head;
  logic [CW-1:0]         fifo_cnt;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [RES_W-1:0] v);
    return {{(SUM_W-RES_W){v[RES_W-1]}}, v};
  endfunction

  assign start_ok = (state_q == IDLE) && start && (img_w >= K) && (img_h >= K);
  // Credit covers windows in flight plus results parked in the FIFO.
  assign win_valid = (state_q == ISSUE) && (credit_q < CW'(OUT_DEPTH));
  assign accept    = win_valid && bus.win_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign col_end   = coord_q.col == DIM_W_MAX'(w_q - K);
  assign row_end   = coord_q.row == DIM_W_MAX'(h_q - K);
  assign win_last  = col_end && row_end;
  assign sum       = sext(bus.res1) + sext(bus.res2) + sext(bus.res3) + sext(bus.res4) + sext(bus.res5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      coord_q     <= '0;
      credit_q    <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      done_q      <= 1'b0;
      credit_q    <= credit_q + CW'(accept) - CW'(pop);
      vld_pipe_q  <= {vld_pipe_q[PIPE_LAT-2:0], accept};
      last_pipe_q <= {last_pipe_q[PIPE_LAT-2:0], accept && win_last};
      unique case (state_q)
        IDLE: if (start) begin
          if (start_ok) begin
            w_q     <= img_w;
            h_q     <= img_h;
            coord_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end else begin
            done_q <= 1'b1;
          end
        end
        ISSUE: if (accept) begin
          if (win_last) state_q <= DRAIN;
          else if (col_end) begin
            coord_q.col <= '0;
            coord_q.row <= coord_q.row + 1'b1;
          end else begin
            coord_q.col <= coord_q.col + 1'b1;
          end
        end
        // Finish on the pop that empties the last credit so done follows it by one cycle.
        DRAIN: if (credit_q == CW'(pop)) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  conv_seq_fifo #(.WIDTH(SUM_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_pipe_q[PIPE_LAT-1]),
    .wdata_i ({last_pipe_q[PIPE_LAT-1], sum}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.win_valid = win_valid;
  assign bus.win_row   = coord_q.row[DIM_W-1:0];
  assign bus.win_col   = coord_q.col[DIM_W-1:0];
  assign bus.out_valid = fifo_cnt != '0;
  assign bus.out_data  = head[SUM_W-1:0];
  assign bus.out_last  = head[SUM_W] && bus.out_valid;

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, bp_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else if (state_q == ISSUE) begin
      if (win_valid && !bus.win_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (!win_valid && !(&bp_q)) bp_q <= bp_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign bp_cycles    = bp_q;
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: a negedge monitor models the datapath, checks issue order and pops results.
module tb_conv_window_sequencer;
  import conv_seq_pkg::*;
  localparam int DIM_W = 10, RES_W = 29, PIPE_LAT = 3, OUT_DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [DIM_W-1:0] img_w = '0, img_h = '0;
  logic busy, done;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles, bp_cycles;
`endif

  conv_window_sequencer_if #(.DIM_W(DIM_W), .RES_W(RES_W)) dut_if ();

  conv_window_sequencer #(.DIM_W(DIM_W), .RES_W(RES_W), .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .img_w        (img_w),
    .img_h        (img_h),
    .busy         (busy),
    .done         (done),
`ifdef CONV_SEQ_STALL_CNT_EN
    .stall_cycles (stall_cycles),
    .bp_cycles    (bp_cycles),
`endif
    .bus          (dut_if)
  );

  always #5 clk = ~clk;

  typedef struct { longint data; bit last; } exp_t;
  exp_t sbq[$];

  int errs = 0, checks = 0, cyc = 0;
  int mode, fw, fh, exp_row, exp_col;
  int acc_cnt, pop_cnt, stall_cnt, first_acc, first_ov, last_pop, done_cyc, start_cyc;
  bit saw_busy, saw_wv, got_done, prev_stall;
  int prev_row, prev_col;
  bit p_v [PIPE_LAT+1];
  int p_r [PIPE_LAT+1];
  int p_c [PIPE_LAT+1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Hand-computed sums of the per-mode product patterns driven below.
  function automatic longint exp_sum(input int md, input int r, input int c);
    case (md)
      0:       return 142296;
      1:       return -64'sd1342177280;
      default: return longint'(r * 64 + c + 7);
    endcase
  endfunction

  task automatic drive_res(input bit v, input int r, input int c);
    logic signed [RES_W-1:0] mn;
    mn = {1'b1, {(RES_W-1){1'b0}}};
    dut_if.res1 = '0; dut_if.res2 = '0; dut_if.res3 = '0; dut_if.res4 = '0; dut_if.res5 = '0;
    if (v) begin
      case (mode)
        0: begin
          dut_if.res1 = -RES_W'(8262); dut_if.res2 = RES_W'(9392); dut_if.res3 = RES_W'(31444);
          dut_if.res4 = RES_W'(47591); dut_if.res5 = RES_W'(62131);
        end
        1: begin
          dut_if.res1 = mn; dut_if.res2 = mn; dut_if.res3 = mn; dut_if.res4 = mn; dut_if.res5 = mn;
        end
        default: begin
          dut_if.res1 = RES_W'(r * 64); dut_if.res2 = RES_W'(c); dut_if.res3 = -RES_W'(1000);
          dut_if.res4 = RES_W'(1000); dut_if.res5 = RES_W'(7);
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i <= PIPE_LAT; i++) p_v[i] = 1'b0;
      prev_stall = 1'b0;
      drive_res(1'b0, 0, 0);
    end else begin : mon
      bit acc;
      exp_t e;
      acc = dut_if.win_valid && dut_if.win_ready;
      if (busy) saw_busy = 1'b1;
      if (dut_if.win_valid) saw_wv = 1'b1;
      if (dut_if.win_valid && prev_stall) begin
        chk_eq("win_row_hold", dut_if.win_row, prev_row);
        chk_eq("win_col_hold", dut_if.win_col, prev_col);
      end
      if (acc) begin
        chk_eq("win_row", dut_if.win_row, exp_row);
        chk_eq("win_col", dut_if.win_col, exp_col);
        if (first_acc < 0) first_acc = cyc;
        e.data = exp_sum(mode, exp_row, exp_col);
        e.last = (exp_row == fh - 5) && (exp_col == fw - 5);
        sbq.push_back(e);
        if (exp_col == fw - 5) begin exp_col = 0; exp_row++; end
        else exp_col++;
        acc_cnt++;
      end
      if (dut_if.win_valid && !dut_if.win_ready) stall_cnt++;
      prev_stall = dut_if.win_valid && !dut_if.win_ready;
      prev_row   = int'(dut_if.win_row);
      prev_col   = int'(dut_if.win_col);
      if (dut_if.out_valid && first_ov < 0) first_ov = cyc;
      if (dut_if.out_valid && dut_if.out_ready) begin
        if (sbq.size() == 0) chk_eq("unexpected_result", dut_if.out_data, 64'hDEAD_0000_0000);
        else begin
          e = sbq.pop_front();
          chk_eq("out_data", dut_if.out_data, e.data);
          chk_eq("out_last", dut_if.out_last, longint'(e.last));
        end
        pop_cnt++;
        last_pop = cyc;
      end
      for (int i = PIPE_LAT; i > 0; i--) begin
        p_v[i] = p_v[i-1]; p_r[i] = p_r[i-1]; p_c[i] = p_c[i-1];
      end
      p_v[0] = acc; p_r[0] = int'(dut_if.win_row); p_c[0] = int'(dut_if.win_col);
      drive_res(p_v[PIPE_LAT], p_r[PIPE_LAT], p_c[PIPE_LAT]);
    end
  end

  task automatic clear_stats(input int w, input int h, input int md);
    mode = md; fw = w; fh = h; exp_row = 0; exp_col = 0;
    acc_cnt = 0; pop_cnt = 0; stall_cnt = 0; first_acc = -1; first_ov = -1; last_pop = -1;
    saw_busy = 1'b0; saw_wv = 1'b0;
  endtask

  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    img_w = DIM_W'(w); img_h = DIM_W'(h); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int md, input bit tgl, input int hold);
    clear_stats(w, h, md);
    dut_if.win_ready = 1'b1;
    dut_if.out_ready = (hold == 0);
    pulse_start(w, h);
    got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; done_cyc = cyc; break; end
      @(posedge clk); #1;
      if (tgl) dut_if.win_ready = ~dut_if.win_ready;
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          chk_eq("credit_limits_issue", acc_cnt, OUT_DEPTH);
          dut_if.out_ready = 1'b1;
        end
      end
    end
    chk_eq("done_seen", got_done, 1);
    chk_eq("sb_drained", sbq.size(), 0);
    dut_if.win_ready = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_win_valid"}, dut_if.win_valid, 0);
    chk_eq({tag, "_out_valid"}, dut_if.out_valid, 0);
    chk_eq({tag, "_out_last"}, dut_if.out_last, 0);
    chk_eq({tag, "_win_row"}, dut_if.win_row, 0);
    chk_eq({tag, "_win_col"}, dut_if.win_col, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dut_if.win_ready = 1'b1;
    dut_if.out_ready = 1'b1;
    drive_res(1'b0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    // 8x6 frame: raster order, latency, last flag, done timing
    run_frame(8, 6, 0, 1'b0, 0);
    chk_eq("f1_pops", pop_cnt, 8);
    chk_eq("f1_first_latency", first_ov - first_acc, PIPE_LAT + 1);
    chk_eq("f1_done_after_pop", done_cyc - last_pop, 1);
    @(negedge clk);
    chk_eq("f1_done_one_cycle", done, 0);
    chk_eq("f1_busy_low", busy, 0);

    // most-negative products sum exactly
    run_frame(6, 5, 1, 1'b0, 0);
    chk_eq("f2_pops", pop_cnt, 2);

    // consumer stalled 40 cycles on a 9x9 frame
    run_frame(9, 9, 2, 1'b0, 40);
    chk_eq("f3_pops", pop_cnt, 25);
    chk_eq("f3_accepts", acc_cnt, 25);
`ifdef CONV_SEQ_STALL_CNT_EN
    chk_eq("f3_bp_nonzero", bp_cycles != 0, 1);
`endif

    // fetch stage toggling ready
    run_frame(7, 6, 2, 1'b1, 0);
    chk_eq("f4_pops", pop_cnt, 6);
    chk_eq("f4_stalls_seen", stall_cnt > 0, 1);
`ifdef CONV_SEQ_STALL_CNT_EN
    chk_eq("f4_stall_cycles", stall_cycles, stall_cnt);
    chk_eq("f4_bp_cycles", bp_cycles, 0);
`endif

    // undersized frame
    run_frame(4, 10, 0, 1'b0, 0);
    chk_eq("f5_done_next_cycle", done_cyc - start_cyc, 1);
    chk_eq("f5_busy_never", saw_busy, 0);
    chk_eq("f5_no_win_valid", saw_wv, 0);
    chk_eq("f5_pops", pop_cnt, 0);

    // reset mid-ISSUE after 5 accepts
    clear_stats(9, 9, 2);
    pulse_start(9, 9);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt >= 5) break;
    end
    chk_eq("f6_reached_5", acc_cnt, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 sbq.delete();
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1 rst = 1'b0;

    // minimal 5x5 frame after the abort
    run_frame(5, 5, 0, 1'b0, 0);
    chk_eq("f7_pops", pop_cnt, 1);
    chk_eq("f7_done_after_pop", done_cyc - last_pop, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
